// File: rtl/workload_predictor.sv
// workload_predictor: task buffer with arrival-rate window driving the worker-clock predict line
module workload_predictor #(
  parameter int DATA_W      = 8,
  parameter int FIFO_DEPTH  = 8,
  parameter int WINDOW      = 16,
  parameter int HI_THRESH   = 4,
  parameter int LO_THRESH   = 1,
  parameter int WAKE_CYCLES = 2,
  parameter int IDLE_HOLD   = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic                            predict,
  output logic [1:0]                      state,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int CW  = WINDOW > 1 ? $clog2(WINDOW) : 1;
  localparam int RW  = $clog2(WINDOW + 1);
  localparam int WKW = $clog2(WAKE_CYCLES + 1);
  localparam int IW  = $clog2(IDLE_HOLD + 1);
  typedef enum logic [1:0] {SLEEP, WAKE, ACTIVE, COOLDOWN} state_t;
  state_t st;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [CW-1:0] cyc;
  logic [RW-1:0] push_cnt, last_rate;
  logic [WKW-1:0] wake_cnt;
  logic [IW-1:0] idle_cnt;
  logic empty, full, push, pop;
  assign empty      = count == '0;
  assign full       = count == LW'(FIFO_DEPTH);
  assign in_ready   = !full && !reset;
  assign out_valid  = !empty && st == ACTIVE;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_data   = empty ? '0 : mem[rd_ptr];
  assign predict    = st != SLEEP;
  assign state      = st;
  assign fifo_level = count;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
      count  <= count + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc       <= '0;
      push_cnt  <= '0;
      last_rate <= '0;
    end else if (cyc == CW'(WINDOW - 1)) begin
      cyc       <= '0;
      push_cnt  <= '0;
      last_rate <= push_cnt + RW'(push);
    end else begin
      cyc      <= cyc + 1'b1;
      push_cnt <= (push_cnt == RW'(WINDOW)) ? push_cnt : push_cnt + RW'(push);
    end
  end
  // Transitions use registered level; only idle expiry looks at the same-cycle push.
  always_ff @(posedge clk) begin
    if (reset) begin
      st       <= SLEEP;
      wake_cnt <= '0;
      idle_cnt <= '0;
    end else begin
      case (st)
        SLEEP: if (!empty || 32'(last_rate) >= HI_THRESH) begin
          st       <= WAKE;
          wake_cnt <= '0;
        end
        WAKE: begin
          wake_cnt <= wake_cnt + 1'b1;
          if (wake_cnt == WKW'(WAKE_CYCLES - 1)) st <= ACTIVE;
        end
        ACTIVE: if (empty && 32'(last_rate) <= LO_THRESH) begin
          st       <= COOLDOWN;
          idle_cnt <= '0;
        end
        COOLDOWN: begin
          if (!empty) begin
            st       <= ACTIVE;
            idle_cnt <= '0;
          end else if (idle_cnt == IW'(IDLE_HOLD - 1)) begin
            st       <= push ? ACTIVE : SLEEP;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: st <= SLEEP;
      endcase
    end
  end
endmodule
